// File: rtl/alu_muldiv_seq_if.sv
// Request/response and shared-ALU signal bundle for the multiply/divide sequencer.
interface alu_muldiv_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_hi;
  logic [WIDTH-1:0] resp_lo;
  logic             resp_err;
  logic             alu_req;
  logic             alu_gnt;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready, alu_gnt, alu_result, alu_carry,
    output req_ready, resp_valid, resp_hi, resp_lo, resp_err, alu_req, alu_a, alu_b, alu_op
  );

  // Requester / ALU-owner side
  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready, alu_gnt, alu_result, alu_carry,
    input  req_ready, resp_valid, resp_hi, resp_lo, resp_err, alu_req, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 16x16 unsigned multiply / 16/16 unsigned restoring divide.
// Borrows the shared ALU for one ADD (multiply) or SUB (divide) per iteration;
// all shifting happens in local registers.
module alu_muldiv_seq #(
  parameter int unsigned WIDTH     = 16,
  parameter logic [15:0] DIVZ_QUOT = 16'hFFFF
) (
  input logic             clk,
  input logic             rst,
  alu_muldiv_seq_if.slave bus
);

  localparam int unsigned CW      = $clog2(WIDTH);
  localparam logic [2:0]  ALU_ADD = 3'b000;
  localparam logic [2:0]  ALU_SUB = 3'b001;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic             op_q, op_d;          // 0 = multiply, 1 = divide
  logic [WIDTH-1:0] b_q, b_d;            // multiplicand or divisor
  logic [WIDTH-1:0] hi_q, hi_d;          // P_hi or remainder R
  logic [WIDTH-1:0] lo_q, lo_d;          // P_lo or quotient Q
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] resp_hi_q, resp_hi_d;
  logic [WIDTH-1:0] resp_lo_q, resp_lo_d;
  logic             resp_err_q, resp_err_d;

  logic [WIDTH-1:0] div_t;
  logic             div_take;
  logic [WIDTH:0]   mul_s;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] alu_a_c, alu_b_c;
  logic [2:0]       alu_op_c;

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      resp_hi_q  <= '0;
      resp_lo_q  <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      b_q        <= b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      resp_hi_q  <= resp_hi_d;
      resp_lo_q  <= resp_lo_d;
      resp_err_q <= resp_err_d;
    end
  end

  // Next-state, iteration step and ALU drive
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    b_d        = b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    resp_hi_d  = resp_hi_q;
    resp_lo_d  = resp_lo_q;
    resp_err_d = resp_err_q;
    alu_a_c    = '0;
    alu_b_c    = '0;
    alu_op_c   = ALU_ADD;

    div_t    = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    div_take = hi_q[WIDTH-1] | bus.alu_carry;
    mul_s    = lo_q[0] ? {bus.alu_carry, bus.alu_result} : {1'b0, hi_q};
    // {S, P_lo} >> 1 written out directly so no always-zero bit is carried
    step_hi  = op_q ? (div_take ? bus.alu_result : div_t) : mul_s[WIDTH:1];
    step_lo  = op_q ? {lo_q[WIDTH-2:0], div_take} : {mul_s[0], lo_q[WIDTH-1:1]};

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d = bus.req_op;
          if (bus.req_op && (bus.req_b == '0)) begin
            resp_err_d = 1'b1;
            resp_lo_d  = DIVZ_QUOT[WIDTH-1:0];
            resp_hi_d  = bus.req_a;
            state_d    = DONE;
          end else begin
            b_d     = bus.req_op ? bus.req_b : bus.req_a;
            hi_d    = '0;
            lo_d    = bus.req_op ? bus.req_a : bus.req_b;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        alu_a_c  = op_q ? div_t : hi_q;
        alu_b_c  = b_q;
        alu_op_c = op_q ? ALU_SUB : ALU_ADD;
        if (bus.alu_gnt) begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            resp_hi_d  = step_hi;
            resp_lo_d  = step_lo;
            resp_err_d = 1'b0;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_hi    = resp_hi_q;
  assign bus.resp_lo    = resp_lo_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.alu_req    = (state_q == RUN);
  assign bus.alu_a      = alu_a_c;
  assign bus.alu_b      = alu_b_c;
  assign bus.alu_op     = alu_op_c;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq with a behavioural shared ALU.
module tb_alu_muldiv_seq;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        err;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  exp_t  sb[$];
  int    checks   = 0;
  int    failures = 0;
  logic  alu_req_seen;
  logic [16:0] alu_sum;
  logic        alu_is_sub;

  always #5 clk = ~clk;

  alu_muldiv_seq_if #(.WIDTH(16)) bus ();

  alu_muldiv_seq #(.WIDTH(16), .DIVZ_QUOT(16'hFFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared ALU model: ADD / SUB with carry (SUB carry = no borrow)
  assign alu_is_sub = (bus.alu_op == 3'b001);
  assign alu_sum    = alu_is_sub ? ({1'b0, bus.alu_a} - {1'b0, bus.alu_b})
                                 : ({1'b0, bus.alu_a} + {1'b0, bus.alu_b});
  assign bus.alu_result = alu_sum[15:0];
  assign bus.alu_carry  = alu_is_sub ? ~alu_sum[16] : alu_sum[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: a response is consumed at the next edge when valid & ready
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected actual=%0h_%0h required=none", bus.resp_hi, bus.resp_lo);
        end else begin
          e = sb.pop_front();
          check("resp_hi", 64'(bus.resp_hi), 64'(e.hi));
          check("resp_lo", 64'(bus.resp_lo), 64'(e.lo));
          check("resp_err", 64'(bus.resp_err), 64'(e.err));
        end
      end
    end
  end

  // Track ALU requests
  initial begin
    forever begin
      @(negedge clk);
      if (bus.alu_req === 1'b1) alu_req_seen = 1'b1;
    end
  end

  // Issue one request (called at posedge+1 with the block idle) and follow it
  task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_hi, input logic [15:0] exp_lo,
                        input logic exp_err, input int exp_lat, input logic stall,
                        input logic hold);
    exp_t e;
    int   lat;
    logic [32:0] snap;
    e.hi = exp_hi; e.lo = exp_lo; e.err = exp_err;
    sb.push_back(e);
    alu_req_seen  = 1'b0;
    bus.resp_ready = !hold;
    check("accept_ready", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = -1;
    if (bus.resp_valid) lat = 0;
    else begin
      for (int n = 1; n <= 40; n++) begin
        bus.alu_gnt = stall ? !(n inside {2, 5, 8, 11, 14}) : 1'b1;
        if (n > 1) check("busy_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        if (bus.resp_valid) begin
          lat = n;
          break;
        end
      end
    end
    bus.alu_gnt = 1'b1;
    check("latency", 64'(lat), 64'(exp_lat));
    if (hold) begin
      snap = {bus.resp_hi, bus.resp_lo, bus.resp_err};
      for (int k = 0; k < 3; k++) begin
        if (k == 1) begin
          bus.req_valid = 1'b1;
          bus.req_op    = 1'b0;
          bus.req_a     = 16'h0003;
          bus.req_b     = 16'h0005;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("hold_outputs", 64'({bus.resp_hi, bus.resp_lo, bus.resp_err}), 64'(snap));
        check("hold_valid", 64'(bus.resp_valid), 64'd1);
        check("hold_ready", 64'(bus.req_ready), 64'd0);
      end
      // Request presented in the same cycle the response is taken
      bus.resp_ready = 1'b1;
      bus.req_valid  = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("idle_ready", 64'(bus.req_ready), 64'd1);
      check("idle_valid", 64'(bus.resp_valid), 64'd0);
      @(posedge clk); #1;
      check("no_accept_in_done", 64'(bus.req_ready), 64'd1);
    end else begin
      @(posedge clk); #1;
      check("idle_ready", 64'(bus.req_ready), 64'd1);
      check("idle_valid", 64'(bus.resp_valid), 64'd0);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    bus.alu_gnt    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({bus.req_ready, bus.resp_valid, bus.resp_hi, bus.resp_lo, bus.resp_err,
               bus.alu_req, bus.alu_a, bus.alu_b, bus.alu_op}),
          64'({1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 3'b000}));
    #2 rst = 1'b0;
    @(posedge clk); #1;

    //     op    a         b         hi        lo        err   lat stall hold
    run_op(1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, 16, 1'b0, 1'b0);
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 16, 1'b0, 1'b0);
    run_op(1'b0, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 16, 1'b0, 1'b0);
    run_op(1'b1, 16'h03E8, 16'h0007, 16'h0006, 16'h008E, 1'b0, 16, 1'b0, 1'b0);
    run_op(1'b1, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0, 16, 1'b0, 1'b0);
    run_op(1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 16, 1'b0, 1'b0);
    run_op(1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 0,  1'b0, 1'b0);
    check("divz_no_alu_req", 64'(alu_req_seen), 64'd0);
    run_op(1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, 21, 1'b1, 1'b1);

    // Reset in the middle of a multiply; the operation is discarded
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b0;
    bus.req_a     = 16'h1234;
    bus.req_b     = 16'h5678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrun_reset_outputs",
          64'({bus.req_ready, bus.resp_valid, bus.resp_hi, bus.resp_lo, bus.resp_err,
               bus.alu_req, bus.alu_a, bus.alu_b, bus.alu_op}),
          64'({1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 3'b000}));
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op(1'b1, 16'hFFFF, 16'h0010, 16'h000F, 16'h0FFF, 1'b0, 16, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
